lap_leaderboard: RTL and testbench
==================================

// Module: lap_leaderboard
// PURPOSE
//  Top-3 record store fed by the stopwatch time bus; drives the seven-seg display mux, rank LEDs and sound triggers.
//  Keeps two ranked tables: SLOW (count-up runs, smaller time = better) and FAST (count-down runs, larger remaining = better).
//  Insertion is a small FSM with a ready/valid handshake; a registered read port selects a table entry or live time.
// PARAMETERS
//  TIME_W   39   width of stopwatch time word (packed digits; compared as unsigned integer)
//  DEPTH    3    entries per table (fixed 3; rank/sound ports are 3 bits)
// PORTS
//  clock         in   1       system clock (100 MHz)
//  rst           in   1       synchronous, active-high reset (debounced); clears both tables
//  clear         in   1       synchronous table wipe, same effect as rst on tables/outputs
//  record_valid  in   1       one-cycle request to record time_in
//  record_ready  out  1       high when FSM is IDLE and can accept a record
//  record_mode   in   1       0 = SLOW table, 1 = FAST table
//  time_in       in   TIME_W  live stopwatch time; sampled on accept
//  display_mode  in   3       read select: 0-2 SLOW rank1-3, 4-6 FAST rank1-3, 3/7 live time_in
//  disp_time     out  TIME_W  selected value, registered
//  rank          out  3       one-hot rank LED of last record (100=1st,010=2nd,001=3rd,000=not placed)
//  lb_mode       out  2       table of last record: 01=SLOW, 10=FAST, 00=none since reset/clear
//  sound         out  3       one-cycle pulse, same encoding as rank, on successful placement
// BEHAVIOUR
//  Reset/clear: all entries invalid, state IDLE, record_ready=1, rank=0, lb_mode=0, sound=0, disp_time=0.
//  rst/clear mid-insert: operation aborted, nothing written, no sound pulse. clear with record_valid: clear wins.
//  FSM: IDLE -> CMP -> WRITE -> IDLE.
//   IDLE: record_ready=1; on record_valid latch time_in/record_mode, go CMP. Else stay.
//   CMP: compute insert position p in {0,1,2,none} against target table, register p.
//   WRITE: shift entries p..1 down one slot (entry 3 dropped), write new at p, mark valid;
//          update rank/lb_mode; pulse sound for exactly this cycle's registered output.
//  Latency: accept at edge N; rank/lb_mode/sound/table update visible after edge N+2; record_ready low
//   for cycles N+1..N+2, high again from N+3. record_valid while record_ready=0 is ignored (no queue).
//  Placement: invalid slots always accept. SLOW: new < entry; FAST: new > entry. Ties: new goes after
//   existing equal entries (older record keeps higher rank). Full table, not better than rank 3: no write,
//   rank=000, lb_mode updated, no sound.
//  time_in == 0 is rejected: no write, rank=000, no sound (zero-time beep is owned elsewhere).
//  rank and lb_mode hold until next completed record, clear, or rst.
//  disp_time: registered, 1-cycle latency from display_mode/table/time_in; invalid entry reads 0.
//  Tables change only in WRITE; never partially updated.
// TESTING
//  1 rst, then record SLOW 500 -> after 2 cycles rank=100, sound=100 for 1 cycle, lb_mode=01, sel0 reads 500.
//  2 SLOW 500,300,400,600 -> table 300,400,500; last rank=000, no sound; sel1 reads 400.
//  3 FAST 200,900,200 -> table 900,200,200(new); third record rank=001; sel4 reads 900.
//  4 record_valid on 3 consecutive cycles -> only first accepted, record_ready 1,0,0,1 pattern.
//  5 clear asserted in CMP cycle -> no write, no sound, all sel reads 0, rank=000, lb_mode=00.
//  6 time_in=0 record -> rank=000, no sound; sel3 with time_in=12345 -> disp_time=12345 next cycle.

Source files
------------

// File: rtl/lap_leaderboard.sv
// Top-3 lap record store: two ranked tables (SLOW = lowest time wins, FAST = highest
// remaining wins) filled through a three-state insert FSM, with a registered read mux.
module lap_leaderboard #(
  parameter int TIME_W = 39,
  parameter int DEPTH  = 3
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_record_valid,
  output logic              o_record_ready,
  input  logic              i_record_mode,
  input  logic [TIME_W-1:0] i_time_in,
  input  logic [2:0]        i_display_mode,
  output logic [TIME_W-1:0] o_disp_time,
  output logic [2:0]        o_rank,
  output logic [1:0]        o_lb_mode,
  output logic [2:0]        o_sound
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] POS_NONE = 2'd3;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_wipe;

  logic [TIME_W-1:0] r_tab   [2][DEPTH];
  logic              r_valid [2][DEPTH];
  logic [TIME_W-1:0] r_new_time;
  logic              r_mode;
  logic [1:0]        r_pos;
  logic [1:0]        w_pos;
  logic [2:0]        w_onehot;
  logic [TIME_W-1:0] w_disp_next;

  logic [TIME_W-1:0] r_disp_time;
  logic [2:0]        r_rank;
  logic [1:0]        r_lb_mode;
  logic [2:0]        r_sound;

  assign w_wipe         = i_rst | i_clear;
  assign o_record_ready = (r_state == S_IDLE);
  assign o_disp_time    = r_disp_time;
  assign o_rank         = r_rank;
  assign o_lb_mode      = r_lb_mode;
  assign o_sound        = r_sound;

  always_ff @(posedge i_clock) begin
    if (w_wipe) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_record_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_CMP;
        end
      end
      S_CMP:   w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Lowest slot that is empty or strictly worse; equal entries keep their rank.
  always_comb begin
    w_pos = POS_NONE;
    if (r_new_time != '0) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (!r_valid[r_mode][i] ||
            (r_mode ? (r_new_time > r_tab[r_mode][i]) : (r_new_time < r_tab[r_mode][i])))
          w_pos = 2'(i);
      end
    end
  end

  always_comb begin
    case (r_pos)
      2'd0:    w_onehot = 3'b100;
      2'd1:    w_onehot = 3'b010;
      2'd2:    w_onehot = 3'b001;
      default: w_onehot = 3'b000;
    endcase
  end

  always_comb begin
    w_disp_next = i_time_in;
    if (i_display_mode[1:0] != 2'd3) begin
      if (r_valid[i_display_mode[2]][i_display_mode[1:0]])
        w_disp_next = r_tab[i_display_mode[2]][i_display_mode[1:0]];
      else
        w_disp_next = '0;
    end
  end

  // NOTE: the tables are a handful of flops, not a RAM, so they are reset explicitly;
  // rst and clear must both leave every entry invalid and reading zero.
  always_ff @(posedge i_clock) begin
    r_sound <= 3'b000;
    if (w_wipe) begin
      for (int t = 0; t < 2; t++) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_tab[t][i]   <= '0;
          r_valid[t][i] <= 1'b0;
        end
      end
      r_new_time  <= '0;
      r_mode      <= 1'b0;
      r_pos       <= POS_NONE;
      r_rank      <= 3'b000;
      r_lb_mode   <= 2'b00;
      r_disp_time <= '0;
    end else begin
      if (w_accept) begin
        r_new_time <= i_time_in;
        r_mode     <= i_record_mode;
      end
      if (r_state == S_CMP)
        r_pos <= w_pos;
      if (r_state == S_WRITE) begin
        // NOTE: non-blocking shift reads the pre-edge entries, so order of the loop is irrelevant.
        for (int i = DEPTH - 1; i >= 1; i--) begin
          if (i > int'(r_pos)) begin
            r_tab[r_mode][i]   <= r_tab[r_mode][i-1];
            r_valid[r_mode][i] <= r_valid[r_mode][i-1];
          end
        end
        if (r_pos != POS_NONE) begin
          r_tab[r_mode][r_pos]   <= r_new_time;
          r_valid[r_mode][r_pos] <= 1'b1;
          r_sound                <= w_onehot;
        end
        r_rank    <= w_onehot;
        r_lb_mode <= r_mode ? 2'b10 : 2'b01;
      end
      r_disp_time <= w_disp_next;
    end
  end

endmodule

// File: tb/tb_lap_leaderboard.sv
// Directed bench for lap_leaderboard: hand-computed table contents, rank/sound timing,
// handshake back-pressure, abort by clear and zero-time rejection.
module tb_lap_leaderboard;

  localparam int TIME_W = 39;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              record_valid;
  logic              record_ready;
  logic              record_mode;
  logic [TIME_W-1:0] time_in;
  logic [2:0]        display_mode;
  logic [TIME_W-1:0] disp_time;
  logic [2:0]        rank;
  logic [1:0]        lb_mode;
  logic [2:0]        sound;

  int n_vec = 0;
  int n_err = 0;

  lap_leaderboard #(.TIME_W(TIME_W), .DEPTH(3)) dut (
    .i_clock        (clk),
    .i_rst          (rst),
    .i_clear        (clear),
    .i_record_valid (record_valid),
    .o_record_ready (record_ready),
    .i_record_mode  (record_mode),
    .i_time_in      (time_in),
    .i_display_mode (display_mode),
    .o_disp_time    (disp_time),
    .o_rank         (rank),
    .o_lb_mode      (lb_mode),
    .o_sound        (sound)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one record and check the handshake plus the result two edges after accept.
  task automatic do_record(input string tag, input logic mode, input logic [TIME_W-1:0] t,
                           input logic [2:0] exp_rank);
    check({tag, " ready before"}, 64'(record_ready), 64'd1);
    record_valid = 1'b1;
    record_mode  = mode;
    time_in      = t;
    tick();
    record_valid = 1'b0;
    check({tag, " ready cmp"}, 64'(record_ready), 64'd0);
    tick();
    check({tag, " sound early"}, 64'(sound), 64'd0);
    tick();
    check({tag, " rank"}, 64'(rank), 64'(exp_rank));
    check({tag, " sound"}, 64'(sound), 64'(exp_rank));
    check({tag, " lb_mode"}, 64'(lb_mode), mode ? 64'd2 : 64'd1);
    check({tag, " ready after"}, 64'(record_ready), 64'd1);
    tick();
    check({tag, " sound gone"}, 64'(sound), 64'd0);
  endtask

  task automatic read(input string tag, input logic [2:0] sel, input logic [TIME_W-1:0] exp);
    display_mode = sel;
    tick();
    check(tag, 64'(disp_time), 64'(exp));
  endtask

  task automatic wipe();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    record_valid = 1'b0;
    record_mode  = 1'b0;
    time_in      = '0;
    display_mode = 3'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst ready", 64'(record_ready), 64'd1);
    check("rst rank", 64'(rank), 64'd0);
    check("rst lb_mode", 64'(lb_mode), 64'd0);
    check("rst sound", 64'(sound), 64'd0);
    check("rst disp", 64'(disp_time), 64'd0);

    // 1: first SLOW record
    do_record("t1 slow500", 1'b0, 39'd500, 3'b100);
    read("t1 sel0", 3'd0, 39'd500);
    read("t1 sel1 empty", 3'd1, 39'd0);

    // 2: SLOW ordering and full-table miss
    wipe();
    do_record("t2 slow500", 1'b0, 39'd500, 3'b100);
    do_record("t2 slow300", 1'b0, 39'd300, 3'b100);
    do_record("t2 slow400", 1'b0, 39'd400, 3'b010);
    do_record("t2 slow600", 1'b0, 39'd600, 3'b000);
    read("t2 sel0", 3'd0, 39'd300);
    read("t2 sel1", 3'd1, 39'd400);
    read("t2 sel2", 3'd2, 39'd500);
    check("t2 rank hold", 64'(rank), 64'd0);

    // 3: FAST ordering with a tie
    do_record("t3 fast200", 1'b1, 39'd200, 3'b100);
    do_record("t3 fast900", 1'b1, 39'd900, 3'b100);
    do_record("t3 fast200b", 1'b1, 39'd200, 3'b001);
    read("t3 sel4", 3'd4, 39'd900);
    read("t3 sel5", 3'd5, 39'd200);
    read("t3 sel6", 3'd6, 39'd200);
    read("t3 slow intact", 3'd0, 39'd300);

    // 4: valid held for three cycles, only the first is accepted
    check("t4 ready c0", 64'(record_ready), 64'd1);
    record_valid = 1'b1;
    record_mode  = 1'b1;
    time_in      = 39'd1000;
    tick();
    check("t4 ready c1", 64'(record_ready), 64'd0);
    time_in = 39'd2000;
    tick();
    check("t4 ready c2", 64'(record_ready), 64'd0);
    time_in = 39'd3000;
    tick();
    record_valid = 1'b0;
    check("t4 ready c3", 64'(record_ready), 64'd1);
    check("t4 rank", 64'(rank), 64'b100);
    tick();
    tick();
    check("t4 ready idle", 64'(record_ready), 64'd1);
    read("t4 sel4", 3'd4, 39'd1000);
    read("t4 sel5", 3'd5, 39'd900);
    read("t4 sel6", 3'd6, 39'd200);

    // 5: clear during CMP aborts the insert
    record_valid = 1'b1;
    record_mode  = 1'b0;
    time_in      = 39'd100;
    tick();
    record_valid = 1'b0;
    clear        = 1'b1;
    tick();
    clear = 1'b0;
    check("t5 ready", 64'(record_ready), 64'd1);
    check("t5 sound a", 64'(sound), 64'd0);
    tick();
    check("t5 sound b", 64'(sound), 64'd0);
    check("t5 rank", 64'(rank), 64'd0);
    check("t5 lb_mode", 64'(lb_mode), 64'd0);
    for (int s = 0; s < 8; s++) begin
      if (s != 3 && s != 7) read($sformatf("t5 sel%0d", s), 3'(s), 39'd0);
    end

    // 6: zero time rejected, then live time readout
    do_record("t6 zero", 1'b0, 39'd0, 3'b000);
    read("t6 sel0", 3'd0, 39'd0);
    time_in = 39'd12345;
    read("t6 sel3", 3'd3, 39'd12345);
    time_in = 39'h4_0000_0001;
    read("t6 sel7 wide", 3'd7, 39'h4_0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
